inv_sub_bytes_seq: RTL



---
 rtl/inv_sub_bytes_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES inverse SubBytes: one byte per 8 cycles. Each byte goes through the inverse
// affine map and is then inverted in GF(2^8) as x^254 by square-and-multiply.
module inv_sub_bytes_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StLoad, StIter, StDone} state_e;

    state_e       state_q, state_d;
    logic [127:0] buf_q, buf_d;
    logic [127:0] out_q, out_d;
    logic [3:0]   idx_q, idx_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [7:0]   x_q, x_d;
    logic [7:0]   t_q, t_d;

    logic [6:0]   boff;
    logic [7:0]   cur_byte;
    logic [7:0]   aff;
    logic [7:0]   sq;

    // GF(2^8) multiply mod x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a_i = b_(i+2) ^ b_(i+5) ^ b_(i+7) ^ d_i, i.e. rotate-rights by 2, 5 and 7.
    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ {b[6:0], b[7]} ^ 8'h05;
    endfunction

    // Byte 0 sits in the top bits, so the bit offset of byte idx is 8*(15-idx).
    assign boff     = {~idx_q, 3'b000};
    assign cur_byte = buf_q[boff +: 8];
    assign aff      = inv_affine(cur_byte);
    assign sq       = gmul(t_q, t_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = StLoad;
            StLoad: state_d = StIter;
            StIter: if (cnt_q == 3'd6) state_d = (idx_q == 4'd15) ? StDone : StLoad;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q == StLoad) || (state_q == StIter);
        out_state = out_q;
    end

    always_comb begin
        buf_d = buf_q;
        out_d = out_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        x_d   = x_q;
        t_d   = t_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    buf_d = in_state;
                    idx_d = 4'd0;
                end
            end
            StLoad: begin
                x_d   = aff;
                t_d   = aff;
                cnt_d = 3'd0;
            end
            StIter: begin
                if (cnt_q == 3'd6) begin
                    out_d[boff +: 8] = sq;
                    if (idx_q != 4'd15) idx_d = idx_q + 4'd1;
                end else begin
                    // t <- t^2 * x walks the exponent 1, 3, 7, ..., 127.
                    t_d   = gmul(sq, x_q);
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
            out_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            x_q   <= '0;
            t_q   <= '0;
        end else begin
            buf_q <= buf_d;
            out_q <= out_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            x_q   <= x_d;
            t_q   <= t_d;
        end
    end

endmodule
